usbfs_in_ep_seq: RTL and testbench

IN-endpoint sequencer for the full-speed USB device datapath. It sits directly upstream of the packet transmitter. It does four things:
- loads one payload packet from a byte stream into the transmitter's write buffer;
- answers host IN tokens with DATA0/DATA1, NAK or (optionally) STALL;
- tracks the data toggle;
- retries unacknowledged packets until the host ACKs them.

---
 rtl/usbfs_in_ep_seq.sv | 160 ++++++++++++++++
 tb/tb_usbfs_in_ep_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/usbfs_in_ep_seq.sv
// Full-speed USB IN-endpoint sequencer: loads one packet into the transmitter buffer, answers IN
// tokens with DATA0/DATA1/NAK, tracks the toggle and retries until ACKed. Optional STALL via
// USBFS_IN_EP_STALL_EN.
module usbfs_in_ep_seq #(
  parameter int unsigned MAX_PKT     = 8,
  parameter int unsigned ACK_TIMEOUT = 24
) (
  input  logic                         i_clk_12MHz,
  input  logic                         i_rst,
  input  logic                         i_dataValid,
  output logic                         o_dataReady,
  input  logic [7:0]                   i_dataByte,
  input  logic                         i_dataLast,
  input  logic                         i_inToken,
  input  logic                         i_ackRcvd,
  input  logic                         i_toggleClr,
  input  logic                         i_stall,
  output logic                         o_txValid,
  input  logic                         i_txReady,
  output logic [3:0]                   o_txPid,
  input  logic                         i_txEopDone,
  output logic                         o_wrEn,
  output logic [$clog2(MAX_PKT)-1:0]   o_wrIdx,
  output logic [7:0]                   o_wrByte,
  output logic [$clog2(MAX_PKT+1)-1:0] o_wrNBytes,
  output logic                         o_pktSent,
  output logic                         o_dataToggle
);

  localparam int unsigned IdxW = $clog2(MAX_PKT);
  localparam int unsigned CntW = $clog2(MAX_PKT + 1);
  localparam int unsigned TmrW = $clog2(ACK_TIMEOUT);

  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  typedef enum logic [2:0] {
    StLoad, StFull, StSendData, StDataEop, StWaitAck, StSendHs, StHsEop
  } state_e;

  state_e          state_q, ret_q;
  logic [CntW-1:0] n_bytes_q;
  logic [TmrW-1:0] timer_q;
  logic            toggle_q, tx_valid_q, pkt_sent_q;
  logic [3:0]      tx_pid_q;

  logic accept, pkt_done, stall_hit;

  assign o_dataReady = (state_q == StLoad);
  assign accept      = o_dataReady && i_dataValid;
  // The byte at index MAX_PKT-1 closes the packet even without i_dataLast.
  assign pkt_done    = accept && (i_dataLast || (n_bytes_q == CntW'(MAX_PKT - 1)));

`ifdef USBFS_IN_EP_STALL_EN
  assign stall_hit = i_stall;
`else
  logic unused_stall;
  assign unused_stall = i_stall;
  assign stall_hit    = 1'b0;
`endif

  assign o_wrEn       = accept;
  assign o_wrIdx      = accept ? n_bytes_q[IdxW-1:0] : '0;
  assign o_wrByte     = accept ? i_dataByte : '0;
  assign o_wrNBytes   = accept ? n_bytes_q + CntW'(1) : '0;
  assign o_txValid    = tx_valid_q;
  assign o_txPid      = tx_pid_q;
  assign o_pktSent    = pkt_sent_q;
  assign o_dataToggle = toggle_q;

  always_ff @(posedge i_clk_12MHz) begin
    if (i_rst) begin
      state_q    <= StLoad;
      ret_q      <= StLoad;
      n_bytes_q  <= '0;
      timer_q    <= '0;
      toggle_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_pid_q   <= 4'b0000;
      pkt_sent_q <= 1'b0;
    end else begin
      pkt_sent_q <= 1'b0;
      if (accept) n_bytes_q <= n_bytes_q + CntW'(1);
      unique case (state_q)
        StLoad: begin
          if (i_inToken) begin
            state_q    <= StSendHs;
            tx_valid_q <= 1'b1;
            tx_pid_q   <= stall_hit ? PidStall : PidNak;
            // A packet completed on the token cycle is sent on the next IN.
            ret_q      <= pkt_done ? StFull : StLoad;
          end else if (pkt_done) begin
            state_q <= StFull;
          end
        end
        StFull: begin
          if (i_inToken) begin
            tx_valid_q <= 1'b1;
            if (stall_hit) begin
              state_q  <= StSendHs;
              tx_pid_q <= PidStall;
              ret_q    <= StFull;
            end else begin
              state_q  <= StSendData;
              tx_pid_q <= toggle_q ? PidData1 : PidData0;
            end
          end
        end
        StSendData: begin
          if (i_txReady) begin
            tx_valid_q <= 1'b0;
            state_q    <= StDataEop;
          end
        end
        StDataEop: begin
          if (i_txEopDone) begin
            timer_q <= '0;
            state_q <= StWaitAck;
          end
        end
        StWaitAck: begin
          timer_q <= timer_q + TmrW'(1);
          if (i_ackRcvd) begin
            toggle_q   <= ~toggle_q;
            pkt_sent_q <= 1'b1;
            n_bytes_q  <= '0;
            state_q    <= StLoad;
          end else if (i_inToken) begin
            tx_valid_q <= 1'b1;
            if (stall_hit) begin
              state_q  <= StSendHs;
              tx_pid_q <= PidStall;
              ret_q    <= StWaitAck;
            end else begin
              state_q  <= StSendData;
              tx_pid_q <= toggle_q ? PidData1 : PidData0;
            end
          end else if (timer_q == TmrW'(ACK_TIMEOUT - 1)) begin
            state_q <= StFull;
          end
        end
        StSendHs: begin
          if (i_txReady) begin
            tx_valid_q <= 1'b0;
            state_q    <= StHsEop;
          end
        end
        StHsEop: begin
          if (i_txEopDone) state_q <= ret_q;
        end
        default: state_q <= StLoad;
      endcase
      // Clear overrides an ACK flip on the same cycle.
      if (i_toggleClr) toggle_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usbfs_in_ep_seq.sv
// Directed self-checking bench for usbfs_in_ep_seq (default parameters).
module tb_usbfs_in_ep_seq;

  logic       clk = 1'b0;
  logic       rst, data_valid, data_last, in_token, ack_rcvd, toggle_clr, stall;
  logic       tx_ready, tx_eop_done;
  logic [7:0] data_byte;
  logic       data_ready, tx_valid, wr_en, pkt_sent, data_toggle;
  logic [3:0] tx_pid;
  logic [2:0] wr_idx;
  logic [3:0] wr_nbytes;
  logic [7:0] wr_byte;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  usbfs_in_ep_seq #(.MAX_PKT(8), .ACK_TIMEOUT(24)) dut (
    .i_clk_12MHz (clk),
    .i_rst       (rst),
    .i_dataValid (data_valid),
    .o_dataReady (data_ready),
    .i_dataByte  (data_byte),
    .i_dataLast  (data_last),
    .i_inToken   (in_token),
    .i_ackRcvd   (ack_rcvd),
    .i_toggleClr (toggle_clr),
    .i_stall     (stall),
    .o_txValid   (tx_valid),
    .i_txReady   (tx_ready),
    .o_txPid     (tx_pid),
    .i_txEopDone (tx_eop_done),
    .o_wrEn      (wr_en),
    .o_wrIdx     (wr_idx),
    .o_wrByte    (wr_byte),
    .o_wrNBytes  (wr_nbytes),
    .o_pktSent   (pkt_sent),
    .o_dataToggle(data_toggle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Stream n bytes base, base+1, ...; i_dataLast on the final byte when with_last is set.
  task automatic load(input int n, input logic [7:0] base, input bit with_last);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data_byte  = base + 8'(i);
      data_last  = with_last && (i == n - 1);
      #1;
      chk($sformatf("wr_en[%0d]", i), 32'(wr_en), 1);
      chk($sformatf("wr_idx[%0d]", i), 32'(wr_idx), i);
      chk($sformatf("wr_nbytes[%0d]", i), 32'(wr_nbytes), i + 1);
      chk($sformatf("wr_byte[%0d]", i), 32'(wr_byte), 32'(base) + i);
      tick();
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    #1;
  endtask

  // IN token, expect a transmit request with pid, one stalled-ready cycle, then handshake + EOP.
  task automatic do_in(input string tag, input logic [3:0] pid);
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    chk({tag, "_txvalid"}, 32'(tx_valid), 1);
    chk({tag, "_pid"}, 32'(tx_pid), 32'(pid));
    tick();
    chk({tag, "_pid_held"}, 32'(tx_pid), 32'(pid));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk({tag, "_txvalid_drop"}, 32'(tx_valid), 0);
    tx_eop_done = 1'b1;
    tick();
    tx_eop_done = 1'b0;
  endtask

  task automatic ack(input string tag, input logic exp_toggle);
    ack_rcvd = 1'b1;
    tick();
    ack_rcvd = 1'b0;
    chk({tag, "_pktsent"}, 32'(pkt_sent), 1);
    chk({tag, "_toggle"}, 32'(data_toggle), 32'(exp_toggle));
    tick();
    chk({tag, "_pktsent_pulse"}, 32'(pkt_sent), 0);
  endtask

  initial begin
    rst = 1'b1; data_valid = 0; data_last = 0; data_byte = 0; in_token = 0; ack_rcvd = 0;
    toggle_clr = 0; stall = 0; tx_ready = 0; tx_eop_done = 0;
    tick();
    tick();
    chk("rst_ready", 32'(data_ready), 1);
    chk("rst_txvalid", 32'(tx_valid), 0);
    chk("rst_pid", 32'(tx_pid), 0);
    chk("rst_wren", 32'(wr_en), 0);
    chk("rst_wrnbytes", 32'(wr_nbytes), 0);
    chk("rst_pktsent", 32'(pkt_sent), 0);
    chk("rst_toggle", 32'(data_toggle), 0);
    rst = 1'b0;
    tick();

    // Packet 1: 8 bytes, DATA0, ACK -> toggle 1.
    load(8, 8'h01, 1'b1);
    chk("p1_full_ready", 32'(data_ready), 0);
    do_in("p1", 4'b0011);
    ack("p1_ack", 1'b1);

    // Packet 2: 3 bytes, DATA1, ACK -> toggle 0.
    load(3, 8'h10, 1'b1);
    do_in("p2", 4'b1011);
    ack("p2_ack", 1'b0);

    // Empty buffer NAKs and stays in LOAD; then 8 bytes without last saturate to FULL.
    do_in("nak", 4'b1010);
    chk("nak_ready", 32'(data_ready), 1);
    load(8, 8'h20, 1'b0);
    chk("sat_full", 32'(data_ready), 0);
    do_in("p3", 4'b0011);

    // No ACK for ACK_TIMEOUT cycles -> FULL; upstream data must not be written.
    data_valid = 1'b1;
    repeat (24) begin
      tick();
      chk("retry_no_write", 32'(wr_en), 0);
    end
    data_valid = 1'b0;
    ack_rcvd = 1'b1;
    tick();
    ack_rcvd = 1'b0;
    chk("late_ack_ignored", 32'(pkt_sent), 0);
    chk("late_ack_toggle", 32'(data_toggle), 0);
    do_in("p3_retry", 4'b0011);
    repeat (3) tick();
    do_in("p3_reIN", 4'b0011);
    ack("p3_ack", 1'b1);

    // Toggle clear on the ACK cycle wins over the flip.
    load(2, 8'h30, 1'b1);
    do_in("p4", 4'b1011);
    ack_rcvd = 1'b1;
    toggle_clr = 1'b1;
    tick();
    ack_rcvd = 1'b0;
    toggle_clr = 1'b0;
    chk("clr_pktsent", 32'(pkt_sent), 1);
    chk("clr_toggle", 32'(data_toggle), 0);

    // ACK on the very cycle the timer expires is honoured.
    load(4, 8'h40, 1'b1);
    do_in("p5", 4'b0011);
    repeat (23) tick();
    ack("p5_edge_ack", 1'b1);

`ifdef USBFS_IN_EP_STALL_EN
    load(1, 8'h50, 1'b1);
    stall = 1'b1;
    do_in("stall", 4'b1110);
    stall = 1'b0;
    chk("stall_back_full", 32'(data_ready), 0);
    chk("stall_toggle", 32'(data_toggle), 1);
    do_in("p6", 4'b1011);
    ack("p6_ack", 1'b0);
`endif

    // Reset while SEND_DATA is pending.
    load(1, 8'h60, 1'b1);
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    chk("mid_txvalid", 32'(tx_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_txvalid", 32'(tx_valid), 0);
    chk("mid_rst_ready", 32'(data_ready), 1);
    chk("mid_rst_toggle", 32'(data_toggle), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
